// File: rtl/chinx_pkg.sv
// -----------------------------------------------------------------------------
// chinx_pkg
// Shared types and constants for the chinx fetch front end.
//   pc_state_t        : PC generator FSM states (BOOT, FETCH, HOLD)
//   NPC_SEL_*         : next-PC select codes driving chinx_mux4
//   npc_live_sel()    : fixed-priority encode of live redirect requests
//   npc_rank()        : priority rank of a select code (higher wins)
// -----------------------------------------------------------------------------
package chinx_pkg;

   typedef enum logic [1:0] {
      PC_BOOT  = 2'd0,
      PC_FETCH = 2'd1,
      PC_HOLD  = 2'd2
   } pc_state_t;

   localparam logic [1:0] NPC_SEL_SEQ  = 2'b00;
   localparam logic [1:0] NPC_SEL_BR   = 2'b01;
   localparam logic [1:0] NPC_SEL_EXC  = 2'b10;
   localparam logic [1:0] NPC_SEL_ERET = 2'b11;

   // Exception beats exception-return beats branch beats sequential.
   function automatic logic [1:0] npc_live_sel(input logic excp,
                                               input logic eret,
                                               input logic branch);
      logic [1:0] sel;
      if (excp)        sel = NPC_SEL_EXC;
      else if (eret)   sel = NPC_SEL_ERET;
      else if (branch) sel = NPC_SEL_BR;
      else             sel = NPC_SEL_SEQ;
      return sel;
   endfunction

   // The select encoding is not ordered by priority, so map it to a rank.
   function automatic logic [1:0] npc_rank(input logic [1:0] sel);
      logic [1:0] rank;
      case (sel)
         NPC_SEL_EXC:  rank = 2'd3;
         NPC_SEL_ERET: rank = 2'd2;
         NPC_SEL_BR:   rank = 2'd1;
         default:      rank = 2'd0;
      endcase
      return rank;
   endfunction

endpackage

// File: rtl/chinx_mux4.sv
// -----------------------------------------------------------------------------
// chinx_mux4
// Combinational 4:1 data multiplexer used for next-PC selection.
//   sel    in  2       select (NPC_SEL_* encoding)
//   data0  in  W       sequential PC
//   data1  in  W       branch target
//   data2  in  W       exception vector
//   data3  in  W       exception-return target
//   data_c out W       selected data (combinational)
// -----------------------------------------------------------------------------
module chinx_mux4
   import chinx_pkg::*;
#(
   parameter int unsigned MUX_DATA_WIDTH = 32
) (
   input  logic [1:0]                sel,
   input  logic [MUX_DATA_WIDTH-1:0] data0,
   input  logic [MUX_DATA_WIDTH-1:0] data1,
   input  logic [MUX_DATA_WIDTH-1:0] data2,
   input  logic [MUX_DATA_WIDTH-1:0] data3,
   output logic [MUX_DATA_WIDTH-1:0] data_c
);

   always_comb begin
      data_c = data0;
      case (sel)
         NPC_SEL_BR:   data_c = data1;
         NPC_SEL_EXC:  data_c = data2;
         NPC_SEL_ERET: data_c = data3;
         default:      data_c = data0;
      endcase
   end

endmodule

// File: rtl/chinx_pc_gen.sv
// -----------------------------------------------------------------------------
// chinx_pc_gen
// Program-counter generator: issues instruction-fetch requests, follows
// branch / exception / exception-return redirects and reports each completed,
// non-discarded fetch with a one-cycle inst_valid_o pulse.
//   clk_i, rst_i              clock, async active-high reset
//   stall_i                   downstream stall (honoured once a fetch completes)
//   branch_i / branch_pc_i    branch redirect and target
//   excp_i   / excp_pc_i      exception redirect and vector
//   eret_i   / epc_i          exception-return redirect and target
//   if_req_o / if_addr_o      fetch request and address (held until ack)
//   if_ack_i                  fetch completion, meaningful only with if_req_o
//   pc_o                      PC of the most recently completed fetch
//   inst_valid_o              pulse: pc_o is a new instruction
//   addr_err_o                with inst_valid_o: pc_o is misaligned
// -----------------------------------------------------------------------------
module chinx_pc_gen
   import chinx_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(32'hBFC0_0000)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   input  logic                  branch_i,
   input  logic [ADDR_WIDTH-1:0] branch_pc_i,
   input  logic                  excp_i,
   input  logic [ADDR_WIDTH-1:0] excp_pc_i,
   input  logic                  eret_i,
   input  logic [ADDR_WIDTH-1:0] epc_i,
   output logic                  if_req_o,
   output logic [ADDR_WIDTH-1:0] if_addr_o,
   input  logic                  if_ack_i,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  inst_valid_o,
   output logic                  addr_err_o
);

   // State registers
   pc_state_t             state_q, state_d;
   logic                  if_req_q, if_req_d;
   logic [ADDR_WIDTH-1:0] if_addr_q, if_addr_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  inst_valid_q, inst_valid_d;
   logic                  addr_err_q, addr_err_d;
   logic                  err_wait_q, err_wait_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [1:0]            pend_sel_q, pend_sel_d;
   logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

   // Redirect arbitration
   logic [1:0]            live_sel;
   logic                  use_pend;
   logic [1:0]            npc_sel;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] seq_pc;
   logic [ADDR_WIDTH-1:0] br_tgt;
   logic [ADDR_WIDTH-1:0] exc_tgt;
   logic [ADDR_WIDTH-1:0] eret_tgt;
   logic [ADDR_WIDTH-1:0] npc;
   logic                  ack;
   logic                  misaligned;

   assign live_sel   = npc_live_sel(excp_i, eret_i, branch_i);
   // A same-cycle redirect of equal rank displaces the pending one.
   assign use_pend   = pend_valid_q && (npc_rank(pend_sel_q) > npc_rank(live_sel));
   assign npc_sel    = use_pend ? pend_sel_q : live_sel;
   assign redirect   = (npc_sel != NPC_SEL_SEQ);
   assign seq_pc     = if_addr_q + ADDR_WIDTH'(4);
   assign ack        = if_ack_i && if_req_q;
   assign misaligned = |if_addr_q[1:0];

   // When the pending redirect wins, its saved target replaces the live input
   // on the lane its select code points at.
   assign br_tgt   = use_pend ? pend_pc_q : branch_pc_i;
   assign exc_tgt  = use_pend ? pend_pc_q : excp_pc_i;
   assign eret_tgt = use_pend ? pend_pc_q : epc_i;

   chinx_mux4 #(
      .MUX_DATA_WIDTH (ADDR_WIDTH)
   ) u_npc_mux (
      .sel    (npc_sel),
      .data0  (seq_pc),
      .data1  (br_tgt),
      .data2  (exc_tgt),
      .data3  (eret_tgt),
      .data_c (npc)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      if_addr_d    = if_addr_q;
      pc_d         = pc_q;
      inst_valid_d = 1'b0;
      addr_err_d   = 1'b0;
      err_wait_d   = err_wait_q;
      pend_valid_d = pend_valid_q;
      pend_sel_d   = pend_sel_q;
      pend_pc_d    = pend_pc_q;

      case (state_q)
         PC_BOOT: begin
            state_d = PC_FETCH;
         end

         PC_FETCH: begin
            if (misaligned) begin
               // No request is issued; report the bad PC and park until redirected.
               pc_d         = if_addr_q;
               inst_valid_d = 1'b1;
               addr_err_d   = 1'b1;
               state_d      = PC_HOLD;
               if (redirect) begin
                  if_addr_d  = npc;
                  err_wait_d = 1'b0;
               end else begin
                  err_wait_d = 1'b1;
               end
            end else if (ack) begin
               if (!redirect) begin
                  pc_d         = if_addr_q;
                  inst_valid_d = 1'b1;
               end
               // npc is the sequential PC when nothing redirects.
               if_addr_d    = npc;
               pend_valid_d = 1'b0;
               state_d      = stall_i ? PC_HOLD : PC_FETCH;
            end else if (redirect) begin
               // Request in flight: remember the winning redirect for the ack.
               pend_valid_d = 1'b1;
               pend_sel_d   = npc_sel;
               pend_pc_d    = npc;
            end
         end

         PC_HOLD: begin
            if (redirect) begin
               if_addr_d  = npc;
               err_wait_d = 1'b0;
            end
            if (excp_i || (!stall_i && !err_wait_d)) begin
               state_d = PC_FETCH;
            end
         end

         default: begin
            state_d = PC_BOOT;
         end
      endcase

      if_req_d = (state_d == PC_FETCH) && (if_addr_d[1:0] == 2'b00);
   end

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= PC_BOOT;
         if_req_q     <= 1'b0;
         if_addr_q    <= RESET_PC;
         pc_q         <= RESET_PC;
         inst_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         err_wait_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_sel_q   <= NPC_SEL_SEQ;
         pend_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         if_req_q     <= if_req_d;
         if_addr_q    <= if_addr_d;
         pc_q         <= pc_d;
         inst_valid_q <= inst_valid_d;
         addr_err_q   <= addr_err_d;
         err_wait_q   <= err_wait_d;
         pend_valid_q <= pend_valid_d;
         pend_sel_q   <= pend_sel_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

   assign if_req_o     = if_req_q;
   assign if_addr_o    = if_addr_q;
   assign pc_o         = pc_q;
   assign inst_valid_o = inst_valid_q;
   assign addr_err_o   = addr_err_q;

endmodule

// File: doc/chinx_pc_gen.md
CHINX_PC_GEN -- requirements
Module: chinx_pc_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets the PC and fetch address width.
REQ-002 Parameter RESET_PC, default 32'hBFC0_0000, is the boot fetch address.
REQ-003 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 stall_i  in  1  downstream stall; the block holds after the current fetch completes.
REQ-006 branch_i / branch_pc_i  in  1 / ADDR_WIDTH  branch redirect and its target.
REQ-007 excp_i / excp_pc_i  in  1 / ADDR_WIDTH  exception redirect and its vector.
REQ-008 eret_i / epc_i  in  1 / ADDR_WIDTH  exception-return redirect and its target.
REQ-009 if_req_o / if_addr_o  out  1 / ADDR_WIDTH  instruction-fetch request and its address.
REQ-010 if_ack_i  in  1  fetch completion; valid only while if_req_o=1.
REQ-011 pc_o  out  ADDR_WIDTH  PC of the most recently completed fetch.
REQ-012 inst_valid_o  out  1  one-cycle pulse marking pc_o as a new, non-discarded instruction.
REQ-013 addr_err_o  out  1  qualifies inst_valid_o: pc_o is misaligned.

Function
REQ-014 Next-PC select SHALL be 2'b10 for excp_i, else 2'b11 for eret_i, else 2'b01 for branch_i, else 2'b00 (sequential).
REQ-015 Sequential next PC SHALL be if_addr_o+4, modulo 2^ADDR_WIDTH; 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-016 FSM states SHALL be BOOT, FETCH and HOLD.
REQ-017 BOOT: if_req_o=0; the FSM moves to FETCH on the next edge with if_addr_o=RESET_PC.
REQ-018 FETCH: if_req_o=1; if_req_o and if_addr_o SHALL stay stable until if_ack_i=1.
REQ-019 FETCH ack without redirect or pending redirect: pc_o<=if_addr_o, inst_valid_o<=1, if_addr_o<=next PC.
REQ-020 After a FETCH ack, the FSM goes to HOLD if stall_i=1, else it stays in FETCH, giving back-to-back requests.
REQ-021 A redirect while a request is outstanding and unacknowledged SHALL be latched as a pending redirect.
REQ-022 A later redirect SHALL replace the pending one only if its priority is greater than or equal to the pending one.
REQ-023 Ack with a pending redirect, or a redirect in the same cycle as the ack: inst_valid_o stays 0, pc_o is unchanged, and if_addr_o<=target.
REQ-024 When pending and same-cycle redirects coexist, the higher-priority one SHALL win; pending state then clears.
REQ-025 HOLD: if_req_o=0 and pc_o is held.
REQ-026 HOLD exit: move to FETCH the cycle after stall_i=0.
REQ-027 A redirect in HOLD SHALL load if_addr_o with the target.
REQ-028 excp_i in HOLD SHALL force FETCH regardless of stall_i.
REQ-029 FETCH with if_addr_o[1:0]!=0: no request is issued; next edge sets pc_o<=if_addr_o, inst_valid_o<=1, addr_err_o<=1.
REQ-030 After a misaligned address, the FSM waits in HOLD until a redirect arrives.
REQ-031 addr_err_o SHALL be 0 whenever inst_valid_o=0.

Reset
REQ-032 Async reset SHALL set: state=BOOT, if_req_o=0, if_addr_o=RESET_PC, pc_o=RESET_PC, inst_valid_o=0, addr_err_o=0, pending redirect cleared.
REQ-033 Reset asserted mid-request SHALL drop if_req_o immediately; the outstanding request is abandoned and a late if_ack_i is ignored.

Structure
REQ-034 The state enum pc_state_t and NPC_SEL_SEQ/BR/EXC/ERET constants SHALL reside in shared package chinx_pkg.
REQ-035 The next-PC select SHALL instantiate chinx_mux4 with MUX_DATA_WIDTH=ADDR_WIDTH.
REQ-036 chinx_mux4 inputs: data0=seq, data1=branch, data2=exception, data3=epc.
REQ-037 All outputs SHALL be registered.

Verification
REQ-038 Release reset, ack every cycle -> requests at 0xBFC00000, 0xBFC00004, 0xBFC00008; one inst_valid_o per ack.
REQ-039 branch_i=1, branch_pc_i=0x80001000 while ack is held low 3 cycles -> if_addr_o stable; on ack inst_valid_o=0; next request at 0x80001000.
REQ-040 branch_i and excp_i in the same cycle, excp_pc_i=0xBFC00380 -> next request at 0xBFC00380.
REQ-041 stall_i=1 at ack -> HOLD with if_req_o=0; stall_i=0 -> next request at pc+4; excp_i during stall -> immediate fetch of the vector.
REQ-042 eret_i with epc_i=0x80000002 -> no if_req_o; inst_valid_o=1, addr_err_o=1, pc_o=0x80000002.
REQ-043 Assert rst_i mid-request, then send a late ack -> if_req_o=0 at once, no inst_valid_o, refetch from 0xBFC00000.
